// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with 3-sample majority vote
// Frames are start/data/[parity]/stop; status and data load one cycle after the last stop decision.
module uart_rx_param #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int UART_BPS  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int HALF    = BPS_CNT / 2;
  localparam int CNT_W   = $clog2(BPS_CNT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(HALF + 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rxd_d0_q, rxd_d1_q;

  logic start_det;
  logic at_wrap;
  logic at_decide;
  logic vote;
  logic data_xor;
  logic parity_calc;

  assign start_det = rxd_d1_q & ~rxd_d0_q;
  assign at_wrap   = (clk_cnt_q == CNT_LAST);
  assign at_decide = (clk_cnt_q == SAMP_C);
  // Third sample is the live synchronised line in the decision cycle.
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_d0_q) | (samp_q[1] & rxd_d0_q);
  assign data_xor  = ^shift_q;
  assign parity_calc = (PARITY == 1) ? ~(data_xor ^ par_bit_q) :
                       (PARITY == 2) ?  (data_xor ^ par_bit_q) : 1'b0;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = at_wrap ? '0 : clk_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_bit_d  = par_bit_q;
    ferr_acc_d = ferr_acc_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    if (clk_cnt_q == SAMP_A) samp_d[0] = rxd_d0_q;
    if (clk_cnt_q == SAMP_B) samp_d[1] = rxd_d0_q;

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (start_det) begin
          state_d    = ST_START;
          bit_idx_d  = '0;
          ferr_acc_d = 1'b0;
        end
      end
      ST_START: begin
        if (at_decide && vote) begin
          state_d = ST_IDLE;
        end else if (at_wrap) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (at_decide) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (at_wrap) begin
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? ST_PAR : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      ST_PAR: begin
        if (at_decide) par_bit_d = vote;
        if (at_wrap) begin
          state_d   = ST_STOP;
          bit_idx_d = '0;
        end
      end
      ST_STOP: begin
        // Leave at the final decision so a following start edge is not missed.
        if (at_decide && bit_idx_q == STOP_LAST) begin
          state_d    = ST_IDLE;
          clk_cnt_d  = '0;
          rx_valid_d = 1'b1;
          rx_data_d  = shift_q;
          perr_d     = parity_calc;
          ferr_d     = ferr_acc_q | ~vote;
        end else begin
          if (at_decide) ferr_acc_d = ferr_acc_q | ~vote;
          if (at_wrap) bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      par_bit_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rxd_d0_q   <= 1'b1;
      rxd_d1_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      par_bit_q  <= par_bit_d;
      ferr_acc_q <= ferr_acc_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      rxd_d0_q   <= uart_rxd;
      rxd_d1_q   <= rxd_d0_q;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed vector bench for uart_rx_param
// Three receivers: 8N1, 8E1 and 9N2, all at 16 clocks per bit.
module tb_uart_rx_param;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 62_500;
  localparam int BPS      = 16;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rxd [3];
  logic [7:0] data_a, data_b;
  logic [8:0] data_c;
  logic [2:0] valid, perr, ferr, busy;
  logic [8:0] o_data [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int long_strobes = 0;
  int vcnt [3] = '{0, 0, 0};
  logic prev_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic [8:0] h_data [3][16];
  logic       h_perr [3][16];
  logic       h_ferr [3][16];
  int         h_cyc  [3][16];

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       par;
    logic [1:0] stop;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [11];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[0]), .rx_data(data_a),
    .rx_valid(valid[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .rx_busy(busy[0]));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[1]), .rx_data(data_b),
    .rx_valid(valid[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .rx_busy(busy[1]));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[2]), .rx_data(data_c),
    .rx_valid(valid[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .rx_busy(busy[2]));

  assign o_data[0] = {1'b0, data_a};
  assign o_data[1] = {1'b0, data_b};
  assign o_data[2] = data_c;

  // Strobe capture: history of every rx_valid pulse per receiver.
  always @(negedge sys_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i]) begin
        h_data[i][vcnt[i] % 16] = o_data[i];
        h_perr[i][vcnt[i] % 16] = perr[i];
        h_ferr[i][vcnt[i] % 16] = ferr[i];
        h_cyc[i][vcnt[i] % 16]  = cyc;
        if (prev_valid[i]) long_strobes++;
        vcnt[i]++;
      end
      prev_valid[i] = valid[i];
    end
  end

  function automatic int nbits(input int inst);
    return (inst == 2) ? 9 : 8;
  endfunction

  function automatic int nstop(input int inst);
    return (inst == 2) ? 2 : 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; each bit is held for BPS cycles.
  task automatic send(input int inst, input logic [8:0] data, input logic par, input logic [1:0] stop,
                      input int spike_k, input int max_cyc, output int c0);
    logic fb [16];
    int n;
    fb[0] = 1'b0;
    n = 1;
    for (int b = 0; b < nbits(inst); b++) begin
      fb[n] = data[b];
      n++;
    end
    if (inst == 1) begin
      fb[n] = par;
      n++;
    end
    for (int s = 0; s < nstop(inst); s++) begin
      fb[n] = stop[s];
      n++;
    end
    c0 = cyc;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < BPS; j++) begin
        if (max_cyc >= 0 && k * BPS + j >= max_cyc) return;
        rxd[inst] = (k == spike_k && j == 9) ? ~fb[k] : fb[k];
        @(negedge sys_clk);
      end
    end
  endtask

  task automatic idle(input int inst, input int ncyc);
    rxd[inst] = 1'b1;
    repeat (ncyc) @(negedge sys_clk);
  endtask

  initial begin
    int c0;
    int base;
    vecs[0]  = '{0, 9'h000, 1'b0, 2'b00, 9'h000, 1'b0, 1'b1};
    vecs[1]  = '{0, 9'h07E, 1'b0, 2'b01, 9'h07E, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h0FF, 1'b0, 2'b01, 9'h0FF, 1'b0, 1'b0};
    vecs[3]  = '{1, 9'h003, 1'b1, 2'b01, 9'h003, 1'b1, 1'b0};
    vecs[4]  = '{1, 9'h003, 1'b0, 2'b01, 9'h003, 1'b0, 1'b0};
    vecs[5]  = '{1, 9'h080, 1'b1, 2'b01, 9'h080, 1'b0, 1'b0};
    vecs[6]  = '{1, 9'h080, 1'b0, 2'b01, 9'h080, 1'b1, 1'b0};
    vecs[7]  = '{1, 9'h0C1, 1'b1, 2'b00, 9'h0C1, 1'b0, 1'b1};
    vecs[8]  = '{2, 9'h155, 1'b0, 2'b11, 9'h155, 1'b0, 1'b0};
    vecs[9]  = '{2, 9'h001, 1'b0, 2'b10, 9'h001, 1'b0, 1'b1};
    vecs[10] = '{2, 9'h0AA, 1'b0, 2'b01, 9'h0AA, 1'b0, 1'b1};

    for (int i = 0; i < 3; i++) rxd[i] = 1'b1;
    repeat (3) @(negedge sys_clk);

    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_data[%0d]", i), int'(o_data[i]), 0);
      check($sformatf("reset_valid[%0d]", i), int'(valid[i]), 0);
      check($sformatf("reset_perr[%0d]", i), int'(perr[i]), 0);
      check($sformatf("reset_ferr[%0d]", i), int'(ferr[i]), 0);
      check($sformatf("reset_busy[%0d]", i), int'(busy[i]), 0);
    end
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // 8N1 0xA5 with strobe latency t0+155 (t0 = drive cycle + 1)
    base = vcnt[0];
    send(0, 9'h0A5, 1'b0, 2'b01, -1, -1, c0);
    idle(0, 20);
    check("a5_strobes", vcnt[0] - base, 1);
    check("a5_data", int'(h_data[0][base % 16]), 'hA5);
    check("a5_cycle", h_cyc[0][base % 16] - c0, 156);
    check("a5_perr", int'(h_perr[0][base % 16]), 0);
    check("a5_ferr", int'(h_ferr[0][base % 16]), 0);
    check("a5_busy_after", int'(busy[0]), 0);

    for (int v = 0; v < 11; v++) begin
      base = vcnt[vecs[v].inst];
      send(vecs[v].inst, vecs[v].data, vecs[v].par, vecs[v].stop, -1, -1, c0);
      idle(vecs[v].inst, 24);
      check($sformatf("vec%0d_strobes", v), vcnt[vecs[v].inst] - base, 1);
      check($sformatf("vec%0d_data", v), int'(h_data[vecs[v].inst][base % 16]), int'(vecs[v].exp_data));
      check($sformatf("vec%0d_perr", v), int'(h_perr[vecs[v].inst][base % 16]), int'(vecs[v].exp_perr));
      check($sformatf("vec%0d_ferr", v), int'(h_ferr[vecs[v].inst][base % 16]), int'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_busy", v), int'(busy[vecs[v].inst]), 0);
    end

    // False start: 4-cycle low glitch
    base = vcnt[0];
    rxd[0] = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge sys_clk);
      if (j == 4) rxd[0] = 1'b1;
      if (j == 1) check("glitch_busy_t0", int'(busy[0]), 0);
      if (j == 2) check("glitch_busy_t1", int'(busy[0]), 1);
      if (j == 11) check("glitch_busy_t10", int'(busy[0]), 1);
      if (j == 12) check("glitch_busy_t11", int'(busy[0]), 0);
    end
    idle(0, 20);
    check("glitch_strobes", vcnt[0] - base, 0);
    check("glitch_data", int'(data_a), 'hFF);

    // Back-to-back frames with a one-cycle spike at mid bit 3
    base = vcnt[0];
    send(0, 9'h055, 1'b0, 2'b01, 3, -1, c0);
    send(0, 9'h0AA, 1'b0, 2'b01, 3, -1, c0);
    idle(0, 24);
    check("b2b_strobes", vcnt[0] - base, 2);
    check("b2b_data0", int'(h_data[0][base % 16]), 'h55);
    check("b2b_data1", int'(h_data[0][(base + 1) % 16]), 'hAA);
    check("b2b_spacing", h_cyc[0][(base + 1) % 16] - h_cyc[0][base % 16], 160);
    check("b2b_ferr1", int'(h_ferr[0][(base + 1) % 16]), 0);

    // Break: line low well beyond one frame
    base = vcnt[0];
    rxd[0] = 1'b0;
    repeat (250) @(negedge sys_clk);
    check("break_strobes", vcnt[0] - base, 1);
    check("break_data", int'(h_data[0][base % 16]), 0);
    check("break_ferr", int'(h_ferr[0][base % 16]), 1);
    check("break_busy_low", int'(busy[0]), 0);
    idle(0, 40);
    check("break_release_strobes", vcnt[0] - base, 1);
    check("break_release_busy", int'(busy[0]), 0);

    // Reset during data bit 4 of a 9N2 frame
    base = vcnt[2];
    send(2, 9'h0F0, 1'b0, 2'b11, -1, 5 * BPS + 8, c0);
    check("abort_busy_before", int'(busy[2]), 1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("abort_data", int'(data_c), 0);
    check("abort_valid", int'(valid[2]), 0);
    check("abort_perr", int'(perr[2]), 0);
    check("abort_ferr", int'(ferr[2]), 0);
    check("abort_busy", int'(busy[2]), 0);
    rxd[2] = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("abort_strobes", vcnt[2] - base, 0);
    send(2, 9'h1C3, 1'b0, 2'b11, -1, -1, c0);
    idle(2, 24);
    check("post_abort_strobes", vcnt[2] - base, 1);
    check("post_abort_data", int'(h_data[2][base % 16]), 'h1C3);
    check("post_abort_ferr", int'(h_ferr[2][base % 16]), 0);
    check("post_abort_perr", int'(h_perr[2][base % 16]), 0);

    check("single_cycle_strobes", long_strobes, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
